// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, grant encoding and the
// memory-port arbiter state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // Value of the shared mux select / grant output.
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Pick the port owner for the next transfer.
  // The result only matters when at least one request is present.
  // On a tie, round-robin hands the port to whoever did not have it last;
  // otherwise D wins.
  function automatic logic pick_grant(input logic if_req,
                                      input logic d_req,
                                      input logic last_grant,
                                      input logic rr_enable);
    logic g;
    if (if_req && d_req) begin
      g = rr_enable ? ~last_grant : GRANT_D;
    end else if (d_req) begin
      g = GRANT_D;
    end else begin
      g = GRANT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/mux.sv
// Generic 2:1 mux: sel=1 picks a, sel=0 picks b.
module mux #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? a_i : b_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data
// load/store (D). Each transfer is sequenced IDLE -> BUSY -> DONE, and a
// single-cycle ack goes to the owner in DONE. Every output is registered.
module mem_port_arbiter #(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            grant,
  output logic            busy
);

  import riscv_pkg::*;

  arb_state_e      state_q;
  logic            grant_q, last_grant_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic            if_ack_q, d_ack_q;
  logic [XLEN-1:0] if_rdata_q, d_rdata_q;
  logic            busy_q;

  logic            any_req;
  logic            grant_d;
  logic [XLEN-1:0] mux_addr, mux_wdata;
  logic [XLEN-1:0] if_wdata_none;

  // Pick the next owner. The result is used only in IDLE when a request is present.
  always_comb begin
    any_req       = if_req | d_req;
    grant_d       = pick_grant(if_req, d_req, last_grant_q, RR_ENABLE);
    if_wdata_none = '0;
  end

  // Shared address and write-data mux: A = D side, B = IF side.
  mux #(.W(XLEN)) u_addr_mux (
    .a_i  (d_addr),
    .b_i  (if_addr),
    .sel_i(grant_d),
    .y_o  (mux_addr)
  );

  mux #(.W(XLEN)) u_wdata_mux (
    .a_i  (d_wdata),
    .b_i  (if_wdata_none),
    .sel_i(grant_d),
    .y_o  (mux_wdata)
  );

  // Transfer sequencer. The request is latched on entry to BUSY and held
  // stable until mem_ready. Read data is captured straight into the owner's
  // rdata register on the same edge that raises its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_D;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q      <= BUSY;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            mem_req_q    <= 1'b1;
            mem_we_q     <= (grant_d == GRANT_D) && d_we;
            mem_addr_q   <= mux_addr;
            mem_wdata_q  <= mux_wdata;
            busy_q       <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (grant_q == GRANT_D) begin
              d_ack_q <= 1'b1;
              // A store leaves the previous load data in place.
              if (!mem_we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. u_rr (round-robin) runs most steps and
// its acks are matched against a scoreboard queue. u_fp (fixed priority)
// covers the D-over-IF priority case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // round-robin instance
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, grant, busy;

  // fixed-priority instance
  logic        f_if_req, f_d_req, f_d_we, f_mem_ready;
  logic [31:0] f_if_addr, f_d_addr, f_d_wdata, f_mem_rdata;
  logic [31:0] f_if_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
  logic        f_if_ack, f_d_ack, f_mem_req, f_mem_we, f_grant, f_busy;

  mem_port_arbiter #(.XLEN(32), .RR_ENABLE(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .busy(busy)
  );

  mem_port_arbiter #(.XLEN(32), .RR_ENABLE(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .if_req(f_if_req), .if_addr(f_if_addr), .if_rdata(f_if_rdata), .if_ack(f_if_ack),
    .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
    .d_rdata(f_d_rdata), .d_ack(f_d_ack),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready), .grant(f_grant), .busy(f_busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each ack from u_rr must match the oldest outstanding expectation.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (if_ack === 1'b1 || d_ack === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_ack observed=if%b/d%b expected=none", if_ack, d_ack);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_ack_port", {31'd0, d_ack}, {31'd0, e.is_d});
        chk("sb_ack_single", {31'd0, if_ack & d_ack}, 32'd0);
        chk("sb_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = 32'd100; d_addr = 32'd10; d_wdata = 32'd0; mem_rdata = 32'd0;
    f_if_req = 1'b1; f_d_req = 1'b1; f_d_we = 1'b0; f_mem_ready = 1'b0;
    f_if_addr = 32'd100; f_d_addr = 32'd10; f_d_wdata = 32'd0; f_mem_rdata = 32'd0;

    // reset held 2 cycles with requests high: every output stays 0
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata_we", mem_wdata | {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_fp_mem_req_busy", {30'd0, f_mem_req, f_busy}, 32'd0);
    f_if_req = 1'b0; f_d_req = 1'b0;

    // contention right after reset, zero-wait memory: IF first, then D
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_0000;
    sb.push_back('{1'b0, 32'h1111_0000});
    sb.push_back('{1'b1, 32'h2222_0000});
    tick();
    chk("rr1_grant", {31'd0, grant}, 32'd0);
    chk("rr1_addr", mem_addr, 32'd100);
    chk("rr1_req_busy", {30'd0, mem_req, busy}, 32'd3);
    chk("rr1_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("rr1_if_ack", {31'd0, if_ack}, 32'd1);
    chk("rr1_no_d_ack", {31'd0, d_ack}, 32'd0);
    chk("rr1_done_mem_req", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0;
    mem_rdata = 32'h2222_0000;
    tick();
    chk("rr_idle_busy", {30'd0, mem_req, busy}, 32'd0);
    tick();
    chk("rr2_grant", {31'd0, grant}, 32'd1);
    chk("rr2_addr", mem_addr, 32'd10);
    tick();
    chk("rr2_d_ack", {31'd0, d_ack}, 32'd1);
    chk("rr2_no_if_ack", {31'd0, if_ack}, 32'd0);
    d_req = 1'b0;
    tick();

    // single IF read
    if_req = 1'b1; if_addr = 32'd100; mem_rdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    tick();
    chk("ifrd_addr", mem_addr, 32'd100);
    chk("ifrd_grant", {31'd0, grant}, 32'd0);
    tick();
    chk("ifrd_ack", {31'd0, if_ack}, 32'd1);
    chk("ifrd_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    tick();

    // D store with 4 wait states: request fields stay stable for 5 BUSY cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'd5;
    mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    sb.push_back('{1'b1, 32'h2222_0000});
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("st_hold_req_we", {30'd0, mem_req, mem_we}, 32'd3);
      chk("st_hold_addr", mem_addr, 32'd10);
      chk("st_hold_wdata", mem_wdata, 32'd5);
      chk("st_hold_no_ack", {31'd0, d_ack}, 32'd0);
      if (i == 4) mem_ready = 1'b1;
      tick();
    end
    chk("st_d_ack", {31'd0, d_ack}, 32'd1);
    chk("st_rdata_kept", d_rdata, 32'h2222_0000);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();

    // reset in the second BUSY cycle abandons the transfer without an ack
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("rb_busy1", {31'd0, mem_req}, 32'd1);
    tick();
    reset = 1'b1;
    if_req = 1'b0;
    tick();
    chk("rb_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rb_busy", {31'd0, busy}, 32'd0);
    chk("rb_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("rb_still_idle", {30'd0, mem_req, busy}, 32'd0);
    d_req = 1'b1; d_addr = 32'h80; mem_rdata = 32'h0C0F_FEE0;
    sb.push_back('{1'b1, 32'h0C0F_FEE0});
    tick();
    chk("rb_new_grant", {31'd0, grant}, 32'd1);
    chk("rb_new_addr", mem_addr, 32'h80);
    tick();
    chk("rb_new_ack", {31'd0, d_ack}, 32'd1);
    chk("rb_new_rdata", d_rdata, 32'h0C0F_FEE0);
    d_req = 1'b0;
    tick();

    // fixed priority: D wins every tie, IF served only after d_req drops
    f_if_req = 1'b1; f_d_req = 1'b1; f_mem_ready = 1'b1; f_mem_rdata = 32'h5A5A_0001;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("fp_d_grant", {31'd0, f_grant}, 32'd1);
      chk("fp_d_addr", f_mem_addr, 32'd10);
      tick();
      chk("fp_d_ack", {30'd0, f_if_ack, f_d_ack}, 32'd1);
      chk("fp_d_rdata", f_d_rdata, 32'h5A5A_0001);
      if (t == 2) f_d_req = 1'b0;
      tick();
    end
    f_mem_rdata = 32'h5A5A_0002;
    tick();
    chk("fp_if_grant", {31'd0, f_grant}, 32'd0);
    chk("fp_if_addr", f_mem_addr, 32'd100);
    tick();
    chk("fp_if_ack", {30'd0, f_if_ack, f_d_ack}, 32'd2);
    chk("fp_if_rdata", f_if_rdata, 32'h5A5A_0002);
    f_if_req = 1'b0;
    tick();
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
